// File: rtl/spi_slave_axis_igress_os.sv
// Oversampled SPI slave ingress: synchronises the SPI pins into clk, deserialises
// MOSI words and delivers them through a FWFT FIFO as AXI-Stream beats with tlast.
module spi_slave_axis_igress_os #(
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   MSB_FIRST   = 1,
  parameter int                   DEST_WIDTH  = 8,
  parameter int                   ID_WIDTH    = 8,
  parameter logic [DEST_WIDTH-1:0] AXIS_DEST   = '0,
  parameter logic [ID_WIDTH-1:0]   AXIS_SOURCE = '0
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [1:0]                    spi_mode,
  input  logic                          spi_clk,
  input  logic                          spi_csn,
  input  logic                          spi_mosi,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overrun,
  output logic                          err_partial,
  input  logic                          err_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {ST_DISARMED, ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, csn_prev_q;
  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, shift_in;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]  pend_data_q, pend_data_d;
  logic [LVL_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   err_overrun_q, err_overrun_d, err_partial_q, err_partial_d;
  logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];

  logic sclk_s, csn_s, mosi_s, sample_edge, csn_fall, csn_rise;
  logic push, push_last, partial_set, pop, push_ok, full;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH:0]   head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    csn_s       = csn_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    csn_fall    = csn_prev_q & ~csn_s;
    csn_rise    = ~csn_prev_q & csn_s;
    // Modes 0/3 sample on the rising edge, modes 1/2 on the falling edge.
    sample_edge = (mode_q[1] ^ mode_q[0]) ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
    shift_in    = (MSB_FIRST != 0) ? {shift_q[DATA_WIDTH-2:0], mosi_s}
                                   : {mosi_s, shift_q[DATA_WIDTH-1:1]};
  end

  // NOTE: every variable is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    arm_cnt_d    = arm_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    push         = 1'b0;
    push_last    = 1'b0;
    partial_set  = 1'b0;
    unique case (state_q)
      // The synchroniser output is only trusted once it has been refilled from
      // the pin, so a frame active across reset is never mistaken for a new one.
      ST_DISARMED: begin
        if (arm_cnt_q != ARM_W'(SYNC_STAGES)) arm_cnt_d = arm_cnt_q + ARM_W'(1);
        else if (csn_s)                       state_d   = ST_IDLE;
      end
      ST_IDLE: begin
        if (csn_fall) begin
          mode_d   = spi_mode;
          bitcnt_d = '0;
          shift_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (csn_rise) begin
          state_d     = ST_IDLE;
          partial_set = (bitcnt_q != '0);
          if (pend_valid_q) begin
            push         = 1'b1;
            push_last    = 1'b1;
            pend_valid_d = 1'b0;
          end
        end else if (sample_edge) begin
          shift_d = shift_in;
          if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bitcnt_d     = '0;
            push         = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_data_d  = shift_in;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_comb begin
    level         = wr_ptr_q - rd_ptr_q;
    full          = (level == LVL_W'(FIFO_DEPTH));
    head          = mem_q[rd_ptr_q[PTR_W-1:0]];
    m_axis_tvalid = (level != '0);
    pop           = m_axis_tvalid & m_axis_tready;
    push_ok       = push & (~full | pop);
    wr_ptr_d      = wr_ptr_q + LVL_W'(push_ok);
    rd_ptr_d      = rd_ptr_q + LVL_W'(pop);
    err_overrun_d = (push & full & ~pop) | (err_overrun_q & ~err_clear);
    err_partial_d = partial_set | (err_partial_q & ~err_clear);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sclk_sync_q   <= '0;
      csn_sync_q    <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      csn_prev_q    <= 1'b1;
      state_q       <= ST_DISARMED;
      mode_q        <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      arm_cnt_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_overrun_q <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      csn_sync_q    <= csn_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_s;
      csn_prev_q    <= csn_s;
      state_q       <= state_d;
      mode_q        <= mode_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      arm_cnt_q     <= arm_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_data_q   <= pend_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_overrun_q <= err_overrun_d;
      err_partial_q <= err_partial_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers define which entries are
  // live and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= {push_last, pend_data_q};
  end

  assign m_axis_tdata = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & head[DATA_WIDTH];
  assign m_axis_tdest = AXIS_DEST;
  assign m_axis_tid   = AXIS_SOURCE;
  assign fifo_level   = level;
  assign err_overrun  = err_overrun_q;
  assign err_partial  = err_partial_q;

endmodule
